// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, access size and FSM state types for the load/store unit.
// LSU_MISALIGN_SPLIT_EN adds the second-word states used for word-crossing accesses.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        BYTE,
        HALF,
        WORD
    } size_e;

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        ISSUE_HI,
        WAIT_HI
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;
`endif

    // Unsigned loads have no store counterpart.
    function automatic logic funct3_ok(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: funct3_ok = 1'b1;
            F3_BU, F3_HU:     funct3_ok = !we;
            default:          funct3_ok = 1'b0;
        endcase
    endfunction

    function automatic size_e funct3_size(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   funct3_size = BYTE;
            2'b01:   funct3_size = HALF;
            default: funct3_size = WORD;
        endcase
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            BYTE:    misaligned = 1'b0;
            HALF:    misaligned = off[0];
            default: misaligned = (off != 2'd0);
        endcase
    endfunction

    function automatic logic crosses_word(input size_e sz, input logic [1:0] off);
        case (sz)
            BYTE:    crosses_word = 1'b0;
            HALF:    crosses_word = (off == 2'd3);
            default: crosses_word = (off != 2'd0);
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline request/response and memory port bundle of the load/store unit.
// slave is the controller's view, master is the pipeline/memory environment's view.
interface lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              mem_err;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment: byte enables and write-data shift for either word of an access,
// and read-data shift plus sign/zero extension over a low word and the next word's low bytes.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e       size,
    input  logic        uns,
    input  logic [1:0]  off,
    input  logic        hi,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_lo,
    input  logic [23:0] rdata_hi,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic [3:0]  be_base;
    logic [7:0]  be_span;
    logic [63:0] wdata_span;
    logic [31:0] rdata_sh;

    always_comb begin
        case (size)
            BYTE:    be_base = 4'b0001;
            HALF:    be_base = 4'b0011;
            default: be_base = 4'b1111;
        endcase
    end

    // Both spans cover two words so a word-crossing access can take its upper half from [7:4]/[63:32].
    assign be_span    = {4'b0000, be_base} << off;
    assign wdata_span = {32'h0, wdata} << {off, 3'b000};
    assign be         = hi ? be_span[7:4] : be_span[3:0];
    assign wdata_sh   = hi ? wdata_span[63:32] : wdata_span[31:0];

    always_comb begin
        case (off)
            2'd0:    rdata_sh = rdata_lo;
            2'd1:    rdata_sh = {rdata_hi[7:0],  rdata_lo[31:8]};
            2'd2:    rdata_sh = {rdata_hi[15:0], rdata_lo[31:16]};
            default: rdata_sh = {rdata_hi[23:0], rdata_lo[31:24]};
        endcase
    end

    always_comb begin
        case (size)
            BYTE:    rdata_ext = {{24{rdata_sh[7]  & ~uns}}, rdata_sh[7:0]};
            HALF:    rdata_ext = {{16{rdata_sh[15] & ~uns}}, rdata_sh[15:0]};
            default: rdata_ext = rdata_sh;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one RV32I load or store at a time over a req/gnt/rvalid memory port.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two transactions instead of faulting.
//
// state    | meaning
// IDLE     | req_ready high, waiting for a request
// ISSUE    | mem_req held until granted (low word of a split access)
// WAIT     | waiting for read data or write acknowledge
// ISSUE_HI | split access only: mem_req for word+4
// WAIT_HI  | split access only: waiting on word+4
// RESP     | rsp_valid for one cycle
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input logic  clk,
    input logic  rst_n,
    lsu_if.slave bus
);

    state_e state, state_nxt;

    logic              accept;
    logic              fault;
    size_e             req_size;
    logic [1:0]        req_off;
    logic              rsp_capture;

    logic              we_q;
    logic              uns_q;
    size_e             size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              hi_sel;
    logic [31:0]       al_rdata_lo;
    logic [23:0]       al_rdata_hi;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic [31:0]       al_rdata;

    assign accept   = bus.req_valid && (state == IDLE);
    assign req_size = funct3_size(bus.req_funct3[1:0]);
    assign req_off  = bus.req_addr[1:0];

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic [ADDR_W-3:0] WORD_INC = 1;

    logic        split_req;
    logic        split_q;
    logic [31:0] lo_q;

    assign split_req   = crosses_word(req_size, req_off);
    assign fault       = !funct3_ok(bus.req_we, bus.req_funct3);
    assign hi_sel      = (state == ISSUE_HI);
    // The low word is held while the upper word arrives so both merge before extension.
    assign al_rdata_lo = (state == WAIT_HI) ? lo_q : bus.mem_rdata;
    assign al_rdata_hi = (state == WAIT_HI) ? bus.mem_rdata[23:0] : 24'h0;
    assign rsp_capture = bus.mem_rvalid &&
                         (((state == WAIT) && (!split_q || bus.mem_err)) || (state == WAIT_HI));
`else
    assign fault       = !funct3_ok(bus.req_we, bus.req_funct3) || misaligned(req_size, req_off);
    assign hi_sel      = 1'b0;
    assign al_rdata_lo = bus.mem_rdata;
    assign al_rdata_hi = 24'h0;
    assign rsp_capture = bus.mem_rvalid && (state == WAIT);
`endif

    lsu_align u_align (
        .size      (size_q),
        .uns       (uns_q),
        .off       (addr_q[1:0]),
        .hi        (hi_sel),
        .wdata     (wdata_q),
        .rdata_lo  (al_rdata_lo),
        .rdata_hi  (al_rdata_hi),
        .be        (al_be),
        .wdata_sh  (al_wdata),
        .rdata_ext (al_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = fault ? RESP : ISSUE;
            ISSUE: if (bus.mem_gnt) state_nxt = WAIT;
            WAIT: begin
                if (bus.mem_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    state_nxt = (split_q && !bus.mem_err) ? ISSUE_HI : RESP;
`else
                    state_nxt = RESP;
`endif
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ISSUE_HI: if (bus.mem_gnt) state_nxt = WAIT_HI;
            WAIT_HI:  if (bus.mem_rvalid) state_nxt = RESP;
`endif
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory outputs are zero outside the issue states so reset and idle show a quiet bus.
    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_be    = 4'b0000;
        bus.mem_wdata = 32'h0;
        case (state)
            IDLE: bus.req_ready = 1'b1;
            ISSUE: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                bus.mem_be    = al_be;
                bus.mem_wdata = al_wdata;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ISSUE_HI: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = {addr_q[ADDR_W-1:2] + WORD_INC, 2'b00};
                bus.mem_be    = al_be;
                bus.mem_wdata = al_wdata;
            end
`endif
            RESP: bus.rsp_valid = 1'b1;
            default: begin
            end
        endcase
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= BYTE;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_funct3[2];
                size_q  <= req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                rdata_q <= 32'h0;
                err_q   <= fault;
            end
            if (rsp_capture) begin
                err_q   <= bus.mem_err;
                rdata_q <= (bus.mem_err || we_q) ? 32'h0 : al_rdata;
            end
        end
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_q <= 1'b0;
            lo_q    <= 32'h0;
        end else begin
            if (accept) begin
                split_q <= split_req;
            end
            if ((state == WAIT) && bus.mem_rvalid) begin
                lo_q <= bus.mem_rdata;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl; split-access vectors run when LSU_MISALIGN_SPLIT_EN is defined.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    lsu_if #(.ADDR_W(32)) bus ();

    lsu_ctrl #(.ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        bus.mem_err    = 1'b0;
    endtask

    task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
    endtask

    task automatic chk_issue(input string tag, input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata);
        chk({tag, " mem_req"}, bus.mem_req, 1);
        chk({tag, " mem_we"}, bus.mem_we, we);
        chk({tag, " mem_addr"}, bus.mem_addr, addr);
        chk({tag, " mem_be"}, bus.mem_be, be);
        chk({tag, " mem_wdata"}, bus.mem_wdata, wdata);
        chk({tag, " rsp_valid"}, bus.rsp_valid, 0);
    endtask

    task automatic chk_resp(input string tag, input logic [31:0] rdata, input logic err);
        chk({tag, " rsp_valid"}, bus.rsp_valid, 1);
        chk({tag, " rsp_rdata"}, bus.rsp_rdata, rdata);
        chk({tag, " rsp_err"}, bus.rsp_err, err);
        chk({tag, " mem_req in RESP"}, bus.mem_req, 0);
        @(negedge clk);
        chk({tag, " rsp_valid drop"}, bus.rsp_valid, 0);
        chk({tag, " req_ready back"}, bus.req_ready, 1);
    endtask

    // Single memory access; rsp_valid is checked exactly 3 + gnt_dly + rv_dly cycles after accept.
    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int gnt_dly, input int rv_dly,
                       input logic [31:0] rdata, input logic merr,
                       input logic [31:0] exp_addr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                       input logic exp_err);
        present(we, f3, addr, wdata);
        chk({tag, " req_ready"}, bus.req_ready, 1);
        @(negedge clk);
        idle_inputs();
        for (int k = 0; k <= gnt_dly; k++) begin
            chk_issue(tag, we, exp_addr, exp_be, exp_wdata);
            bus.mem_gnt = (k == gnt_dly);
            @(negedge clk);
        end
        bus.mem_gnt = 1'b0;
        chk({tag, " mem_req after gnt"}, bus.mem_req, 0);
        for (int k = 0; k < rv_dly; k++) begin
            bus.mem_rdata = 32'h5A5A_5A5A;
            @(negedge clk);
            chk({tag, " no early rsp"}, bus.rsp_valid, 0);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        bus.mem_err    = merr;
        @(negedge clk);
        idle_inputs();
        chk_resp(tag, exp_rdata, exp_err);
    endtask

    task automatic txn_fault(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr);
        present(we, f3, addr, 32'h1234_5678);
        chk({tag, " req_ready"}, bus.req_ready, 1);
        @(negedge clk);
        idle_inputs();
        chk_resp(tag, 32'h0, 1'b1);
        chk({tag, " no mem_req"}, bus.mem_req, 0);
    endtask

`ifdef LSU_MISALIGN_SPLIT_EN
    task automatic txn_split(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] a_lo, input logic [3:0] be_lo,
                             input logic [31:0] wd_lo, input logic [31:0] rd_lo,
                             input logic [31:0] a_hi, input logic [3:0] be_hi,
                             input logic [31:0] wd_hi, input logic [31:0] rd_hi,
                             input logic [31:0] exp_rdata);
        present(we, f3, addr, wdata);
        chk({tag, " req_ready"}, bus.req_ready, 1);
        @(negedge clk);
        idle_inputs();
        chk_issue({tag, " lo"}, we, a_lo, be_lo, wd_lo);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        chk({tag, " lo mem_req drop"}, bus.mem_req, 0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rd_lo;
        @(negedge clk);
        idle_inputs();
        chk_issue({tag, " hi"}, we, a_hi, be_hi, wd_hi);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        chk({tag, " hi mem_req drop"}, bus.mem_req, 0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rd_hi;
        @(negedge clk);
        idle_inputs();
        chk_resp(tag, exp_rdata, 1'b0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset req_ready", bus.req_ready, 1);
        chk("reset mem_req", bus.mem_req, 0);
        chk("reset mem_we", bus.mem_we, 0);
        chk("reset mem_be", bus.mem_be, 0);
        chk("reset mem_addr", bus.mem_addr, 0);
        chk("reset mem_wdata", bus.mem_wdata, 0);
        chk("reset rsp_valid", bus.rsp_valid, 0);
        chk("reset rsp_err", bus.rsp_err, 0);
        chk("reset rsp_rdata", bus.rsp_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        //  tag          we    f3     addr          wdata          g  r  rdata          err   maddr         be       mwdata         rsp            rerr
        txn("lb 0x103",  1'b0, F3_B,  32'h0000_0103, 32'h0,        0, 0, 32'h8000_0000, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,         32'hFFFF_FF80, 1'b0);
        txn("sh 0x202",  1'b1, F3_H,  32'h0000_0202, 32'h0000_BEEF, 4, 0, 32'h1234_5678, 1'b0, 32'h0000_0200, 4'b1100, 32'hBEEF_0000, 32'h0,         1'b0);
        txn("lhu 0x10",  1'b0, F3_HU, 32'h0000_0010, 32'h0,        0, 2, 32'h1234_F00D, 1'b0, 32'h0000_0010, 4'b0011, 32'h0,         32'h0000_F00D, 1'b0);
        txn("lh 0x12",   1'b0, F3_H,  32'h0000_0012, 32'h0,        1, 0, 32'h8001_0000, 1'b0, 32'h0000_0010, 4'b1100, 32'h0,         32'hFFFF_8001, 1'b0);
        txn("lbu 0x101", 1'b0, F3_BU, 32'h0000_0101, 32'h0,        0, 0, 32'h0000_F000, 1'b0, 32'h0000_0100, 4'b0010, 32'h0,         32'h0000_00F0, 1'b0);
        txn("lb 0x7",    1'b0, F3_B,  32'h0000_0007, 32'h0,        0, 0, 32'h7F00_0000, 1'b0, 32'h0000_0004, 4'b1000, 32'h0,         32'h0000_007F, 1'b0);
        txn("sb 0x101",  1'b1, F3_B,  32'h0000_0101, 32'h0000_00A5, 1, 1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0100, 4'b0010, 32'h0000_A500, 32'h0,         1'b0);
        txn("sw 0x40",   1'b1, F3_W,  32'h0000_0040, 32'hCAFE_F00D, 0, 0, 32'h0,         1'b0, 32'h0000_0040, 4'b1111, 32'hCAFE_F00D, 32'h0,         1'b0);
        txn("lw err",    1'b0, F3_W,  32'h0000_0020, 32'h0,        0, 0, 32'h5555_5555, 1'b1, 32'h0000_0020, 4'b1111, 32'h0,         32'h0,         1'b1);
        txn("lw 0x24",   1'b0, F3_W,  32'h0000_0024, 32'h0,        0, 0, 32'h8765_4321, 1'b0, 32'h0000_0024, 4'b1111, 32'h0,         32'h8765_4321, 1'b0);

        txn_fault("load f3 011", 1'b0, 3'b011, 32'h0000_0010);
        txn_fault("store f3 100", 1'b1, 3'b100, 32'h0000_0010);
        txn_fault("store f3 101", 1'b1, 3'b101, 32'h0000_0014);

`ifdef LSU_MISALIGN_SPLIT_EN
        txn("lh 0x11 inword", 1'b0, F3_H, 32'h0000_0011, 32'h0, 0, 0, 32'h00AB_CD00, 1'b0,
            32'h0000_0010, 4'b0110, 32'h0, 32'hFFFF_ABCD, 1'b0);
        txn_split("lw 0x6 split", 1'b0, F3_W, 32'h0000_0006, 32'h0,
                  32'h0000_0004, 4'b1100, 32'h0, 32'hAAAA_1234,
                  32'h0000_0008, 4'b0011, 32'h0, 32'h5678_BBBB, 32'hBBBB_AAAA);
        txn_split("lh 0x13 split", 1'b0, F3_H, 32'h0000_0013, 32'h0,
                  32'h0000_0010, 4'b1000, 32'h0, 32'h3400_0000,
                  32'h0000_0014, 4'b0001, 32'h0, 32'hFFFF_FF12, 32'h0000_1234);
        txn_split("sw 0x3 split", 1'b1, F3_W, 32'h0000_0003, 32'h1122_3344,
                  32'h0000_0000, 4'b1000, 32'h4400_0000, 32'h0,
                  32'h0000_0004, 4'b0111, 32'h0011_2233, 32'h0, 32'h0);
        // Error on the low word ends the access without touching word+4.
        present(1'b0, F3_W, 32'h0000_0006, 32'h0);
        @(negedge clk);
        idle_inputs();
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_err    = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk_resp("split lo err", 32'h0, 1'b1);
`else
        txn_fault("lw 0x6 misaligned", 1'b0, F3_W, 32'h0000_0006);
        txn_fault("lh 0x11 misaligned", 1'b0, F3_H, 32'h0000_0011);
        txn_fault("sw 0x2 misaligned", 1'b1, F3_W, 32'h0000_0002);
        txn_fault("lhu 0x13 misaligned", 1'b0, F3_HU, 32'h0000_0013);
`endif

        // Reset while mem_req is held: the bus must go quiet immediately.
        present(1'b0, F3_W, 32'h0000_0030, 32'h0);
        @(negedge clk);
        idle_inputs();
        chk("rst issue mem_req before", bus.mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rst issue mem_req", bus.mem_req, 0);
        chk("rst issue mem_addr", bus.mem_addr, 0);
        chk("rst issue mem_be", bus.mem_be, 0);
        chk("rst issue req_ready", bus.req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset during WAIT, then a late rvalid that must be ignored.
        present(1'b1, F3_W, 32'h0000_0030, 32'hFFFF_0000);
        @(negedge clk);
        idle_inputs();
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        chk("rst wait mem_req", bus.mem_req, 0);
        rst_n = 1'b0;
        #1;
        chk("rst wait req_ready", bus.req_ready, 1);
        chk("rst wait rsp_valid", bus.rsp_valid, 0);
        chk("rst wait mem_wdata", bus.mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1111_1111;
        @(negedge clk);
        idle_inputs();
        chk("late rvalid rsp_valid", bus.rsp_valid, 0);
        chk("late rvalid req_ready", bus.req_ready, 1);
        chk("late rvalid mem_req", bus.mem_req, 0);
        @(negedge clk);
        chk("late rvalid rsp_valid +1", bus.rsp_valid, 0);

        txn("lbu after rst", 1'b0, F3_BU, 32'h0000_0102, 32'h0, 0, 0, 32'h0080_0000, 1'b0,
            32'h0000_0100, 4'b0100, 32'h0, 32'h0000_0080, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, byte-address width of the request and memory address buses.
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req_valid in 1 pipeline request; req_ready out 1 accept; req_we in 1 store=1/load=0; req_funct3 in 3 RV32I size/sign code; req_addr in ADDR_W byte address; req_wdata in 32 store data, LSB-justified.
REQ-005 SHALL have ports: rsp_valid out 1 one-cycle completion pulse; rsp_rdata out 32 extended load data (0 for stores/errors); rsp_err out 1 access fault.
REQ-006 SHALL have ports: mem_req out 1; mem_gnt in 1; mem_we out 1; mem_addr out ADDR_W word-aligned (bits[1:0]=0); mem_be out 4 byte enables; mem_wdata out 32; mem_rvalid in 1 read data/write ack; mem_rdata in 32; mem_err in 1 qualified by mem_rvalid.

Function
REQ-007 SHALL use FSM states IDLE, ISSUE, WAIT, RESP (plus ISSUE_HI, WAIT_HI when the split feature is compiled in).
REQ-008 SHALL assert req_ready only in IDLE; handshake req_valid&req_ready latches we/funct3/addr/wdata and moves IDLE->ISSUE.
REQ-009 SHALL treat valid funct3 as loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU and stores 000 SB, 001 SH, 010 SW; any other code SHALL go IDLE->RESP with rsp_err=1 and no memory access.
REQ-010 SHALL, with off=addr[1:0], drive mem_be = 0001<<off (byte), 0011<<off (half), 1111 (word) and mem_wdata = req_wdata<<(8*off).
REQ-011 SHALL in ISSUE hold mem_req=1 and mem_addr/mem_be/mem_we/mem_wdata stable until mem_gnt=1, then go to WAIT; mem_req SHALL deassert in the cycle after gnt.
REQ-012 SHALL in WAIT ignore mem_rdata until mem_rvalid=1; stores also wait for mem_rvalid as write acknowledgement.
REQ-013 SHALL on mem_rvalid shift mem_rdata right by 8*off, sign-extend bit 7/15 for LB/LH, zero-extend for LBU/LHU, pass LW unchanged, register into rsp_rdata, go to RESP.
REQ-014 SHALL in RESP assert rsp_valid for exactly one cycle, then return to IDLE; rsp_err = latched mem_err or fault.
REQ-015 SHALL achieve minimum latency of 3 cycles: accept at cycle 0, mem_req at 1 (gnt same cycle), rvalid at 2, rsp_valid at 3.
REQ-016 SHALL, when mem_err=1 with mem_rvalid, report rsp_err=1, rsp_rdata=0, and skip any remaining split half.

Reset
REQ-017 SHALL on rst_n=0 immediately force state IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1.
REQ-018 SHALL, on reset mid-transaction, abandon the access with no response; late mem_rvalid after reset release SHALL be ignored in IDLE.

Configuration
REQ-019 SHALL honour macro LSU_MISALIGN_SPLIT_EN.
REQ-020 SHALL without LSU_MISALIGN_SPLIT_EN fault (rsp_err=1, no memory access) on LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0.
REQ-021 SHALL with LSU_MISALIGN_SPLIT_EN perform any access whose bytes stay within one word as a single access, and split word-crossing accesses into low word (ISSUE/WAIT) then word+4 (ISSUE_HI/WAIT_HI), merging load bytes before extension and splitting mem_be/mem_wdata across both words.

Structure
REQ-022 SHALL place funct3 encodings, size enum (BYTE/HALF/WORD), and FSM state enum in shared package lsu_pkg.
REQ-023 SHALL put byte-enable generation, write-data shift, and read-data shift/extend in a combinational sub-module lsu_align, instantiated in lsu_ctrl.

Verification
REQ-024 SHALL cover: LB addr 0x103, mem_rdata 0x80_00_00_00 -> mem_be=1000, rsp_rdata=0xFFFF_FF80, rsp_valid at cycle 3.
REQ-025 SHALL cover: SH addr 0x202, wdata 0x0000_BEEF, gnt delayed 4 cycles -> mem_be=1100, mem_wdata=0xBEEF_0000 stable throughout, mem_addr=0x200.
REQ-026 SHALL cover: LHU addr 0x10, mem_rdata 0x1234_F00D -> rsp_rdata=0x0000_F00D; funct3=011 -> rsp_err=1, no mem_req.
REQ-027 SHALL cover: LW addr 0x6 -> without macro rsp_err=1, no mem_req; with macro two accesses 0x4 (be 1100) and 0x8 (be 0011), rdata 0xAAAA_xxxx/0xxxxx_BBBB -> 0xBBBB_AAAA.
REQ-028 SHALL cover: mem_err with rvalid on LW -> rsp_err=1, rsp_rdata=0; rst_n low during WAIT -> no rsp_valid, req_ready=1.
